// File: rtl/int_ctrl_pkg.sv
// Shared constants for the int_ctrl interrupt controller: register map,
// ID width, source limit and mode encodings.
package int_ctrl_pkg;

    localparam int unsigned ID_W    = 5;
    localparam int unsigned MAX_SRC = 31;
    localparam int unsigned DATA_W  = 32;

    localparam logic [7:0] OFF_PENDING   = 8'h00;
    localparam logic [7:0] OFF_ENABLE    = 8'h04;
    localparam logic [7:0] OFF_MODE      = 8'h08;
    localparam logic [7:0] OFF_THRESHOLD = 8'h0C;
    localparam logic [7:0] OFF_CLAIM     = 8'h10;
    localparam logic [7:0] OFF_PRIO_BASE = 8'h20;

    localparam logic MODE_LEVEL = 1'b0;
    localparam logic MODE_EDGE  = 1'b1;

    typedef enum logic [2:0] {
        REG_NONE,
        REG_PENDING,
        REG_ENABLE,
        REG_MODE,
        REG_THRESH,
        REG_CLAIM,
        REG_PRIO
    } reg_sel_e;

endpackage

// File: rtl/int_ctrl_if.sv
// RIB slave port of int_ctrl: request, write strobe, address, write/read data.
interface int_ctrl_if;
    import int_ctrl_pkg::*;

    logic              req_i;
    logic              we_i;
    logic [DATA_W-1:0] addr_i;
    logic [DATA_W-1:0] data_i;
    logic [DATA_W-1:0] data_o;

    modport master (output req_i, output we_i, output addr_i, output data_i, input data_o);
    modport slave  (input req_i, input we_i, input addr_i, input data_i, output data_o);

endinterface

// File: rtl/int_ctrl_arb.sv
// Combinational arbiter: highest priority among candidates, lowest ID on a tie.
module int_ctrl_arb
    import int_ctrl_pkg::*;
#(
    parameter int unsigned NUM_SRC = 8,
    parameter int unsigned PRIO_W  = 3
) (
    input  logic [NUM_SRC-1:0] cand_i,
    input  logic [PRIO_W-1:0]  prio_i [NUM_SRC],
    output logic               valid_o,
    output logic [ID_W-1:0]    id_o,
    output logic [PRIO_W-1:0]  prio_o
);

    always_comb begin
        valid_o = 1'b0;
        id_o    = '0;
        prio_o  = '0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            if (cand_i[k] && (!valid_o || prio_i[k] > prio_o)) begin
                valid_o = 1'b1;
                id_o    = ID_W'(k + 1);
                prio_o  = prio_i[k];
            end
        end
    end

endmodule

// File: rtl/int_ctrl.sv
// int_ctrl: platform interrupt controller with RIB claim/complete registers.
// Define INT_CTRL_SYNC_EN to pass each src_i line through a 2-flop synchroniser.
module int_ctrl
    import int_ctrl_pkg::*;
#(
    parameter int unsigned NUM_SRC = 8,
    parameter int unsigned PRIO_W  = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] src_i,
    int_ctrl_if.slave          rib,
    output logic               irq_o,
    output logic [ID_W-1:0]    irq_id_o
);

    logic [NUM_SRC-1:0] line, hist_q, rise;
    logic [NUM_SRC-1:0] pend_q, pend_d, is_q, is_d;
    logic [NUM_SRC-1:0] en_q, en_d, mode_q, mode_d, mode_chg;
    logic [PRIO_W-1:0]  thr_q, thr_d;
    logic [PRIO_W-1:0]  prio_q [NUM_SRC];
    logic [PRIO_W-1:0]  prio_d [NUM_SRC];
    logic               irq_q;
    logic [ID_W-1:0]    irq_id_q;

    logic [NUM_SRC-1:0] cand;
    logic               arb_valid, win;
    logic [ID_W-1:0]    arb_id, win_id, cmpl_id;
    logic [PRIO_W-1:0]  arb_prio;

    reg_sel_e           sel;
    logic [5:0]         word, prio_off;
    logic               rd, wr, claim, cmpl_ok;

`ifdef INT_CTRL_SYNC_EN
    logic [NUM_SRC-1:0] sync1_q, sync2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= src_i;
            sync2_q <= sync1_q;
        end
    end

    assign line = sync2_q;
`else
    assign line = src_i;
`endif

    assign rise = line & ~hist_q;

    // Bus decode
    assign word     = rib.addr_i[7:2];
    assign prio_off = word - OFF_PRIO_BASE[7:2];
    assign rd       = rib.req_i & ~rib.we_i;
    assign wr       = rib.req_i & rib.we_i;

    always_comb begin
        sel = REG_NONE;
        case ({word, 2'b00})
            OFF_PENDING:   sel = REG_PENDING;
            OFF_ENABLE:    sel = REG_ENABLE;
            OFF_MODE:      sel = REG_MODE;
            OFF_THRESHOLD: sel = REG_THRESH;
            OFF_CLAIM:     sel = REG_CLAIM;
            default: begin
                if (word >= OFF_PRIO_BASE[7:2] && 32'(prio_off) < NUM_SRC) sel = REG_PRIO;
            end
        endcase
    end

    // Threshold is applied to the arbiter's winning priority rather than per
    // source; the max over all eligible sources exceeds it iff some source does.
    assign cand = pend_q & en_q & ~is_q;

    int_ctrl_arb #(
        .NUM_SRC (NUM_SRC),
        .PRIO_W  (PRIO_W)
    ) u_arb (
        .cand_i  (cand),
        .prio_i  (prio_q),
        .valid_o (arb_valid),
        .id_o    (arb_id),
        .prio_o  (arb_prio)
    );

    assign win     = arb_valid && (arb_prio > thr_q);
    assign win_id  = win ? arb_id : '0;
    assign claim   = rd && (sel == REG_CLAIM) && win;
    assign cmpl_id = rib.data_i[ID_W-1:0];
    assign cmpl_ok = wr && (sel == REG_CLAIM) && (rib.data_i[DATA_W-1:ID_W] == '0);

    always_comb begin
        en_d   = en_q;
        mode_d = mode_q;
        thr_d  = thr_q;
        prio_d = prio_q;
        is_d   = is_q;
        pend_d = pend_q;
        if (wr) begin
            case (sel)
                REG_ENABLE: en_d   = rib.data_i[NUM_SRC-1:0];
                REG_MODE:   mode_d = rib.data_i[NUM_SRC-1:0];
                REG_THRESH: thr_d  = rib.data_i[PRIO_W-1:0];
                REG_PRIO: begin
                    for (int unsigned k = 0; k < NUM_SRC; k++)
                        if (32'(prio_off) == k) prio_d[k] = rib.data_i[PRIO_W-1:0];
                end
                default: ;
            endcase
        end
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            if (cmpl_ok && 32'(cmpl_id) == k + 1) is_d[k] = 1'b0;
            if (claim && 32'(win_id) == k + 1) is_d[k] = 1'b1;
        end
        mode_chg = mode_d ^ mode_q;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            if (mode_chg[k]) begin
                pend_d[k] = 1'b0;
            end else if (mode_q[k] == MODE_EDGE) begin
                if (claim && 32'(win_id) == k + 1) pend_d[k] = 1'b0;
                if (rise[k]) pend_d[k] = 1'b1;
            end else begin
                pend_d[k] = line[k] & ~is_d[k];
            end
        end
    end

    always_comb begin
        rib.data_o = '0;
        if (rd) begin
            case (sel)
                REG_PENDING: rib.data_o = DATA_W'(pend_q);
                REG_ENABLE:  rib.data_o = DATA_W'(en_q);
                REG_MODE:    rib.data_o = DATA_W'(mode_q);
                REG_THRESH:  rib.data_o = DATA_W'(thr_q);
                REG_CLAIM:   rib.data_o = DATA_W'(win_id);
                REG_PRIO: begin
                    for (int unsigned k = 0; k < NUM_SRC; k++)
                        if (32'(prio_off) == k) rib.data_o = DATA_W'(prio_q[k]);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q   <= '0;
            pend_q   <= '0;
            is_q     <= '0;
            en_q     <= '0;
            mode_q   <= '0;
            thr_q    <= '0;
            irq_q    <= 1'b0;
            irq_id_q <= '0;
            for (int unsigned k = 0; k < NUM_SRC; k++) prio_q[k] <= '0;
        end else begin
            hist_q   <= line;
            pend_q   <= pend_d;
            is_q     <= is_d;
            en_q     <= en_d;
            mode_q   <= mode_d;
            thr_q    <= thr_d;
            prio_q   <= prio_d;
            irq_q    <= win;
            irq_id_q <= win_id;
        end
    end

    assign irq_o    = irq_q;
    assign irq_id_o = irq_id_q;

endmodule

// File: doc/int_ctrl.md
# int_ctrl

Parametrised platform interrupt controller for the tinyriscv core: gathers up to 31 external interrupt sources, latches them as level or edge pending bits, and arbitrates by programmable priority against a threshold. It drives a single registered interrupt request plus winning source ID toward the core's interrupt input, and exposes a claim/complete register interface as a RIB slave. It generalises the core's fixed `INT_BUS` flag input with per-source enable, mode and priority, and an in-service handshake.

## Interface
- NUM_SRC, 8, number of sources, 1..31; source ID k+1 maps to src_i[k]; ID 0 means "none"
- PRIO_W, 3, priority field width; priority 0 = never interrupts
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- src_i  in  NUM_SRC  raw interrupt lines from peripherals
- req_i  in  1  RIB access request
- we_i  in  1  RIB write strobe, qualified by req_i
- addr_i  in  32  RIB address; only addr_i[7:0] decoded, word aligned
- data_i  in  32  RIB write data
- data_o  out  32  RIB read data, combinational, 0 when no read hit
- irq_o  out  1  registered interrupt request to the core
- irq_id_o  out  5  registered ID of the winning source, 0 when irq_o low

## Operation
- Register map (offset): 0x00 PENDING (RO); 0x04 ENABLE; 0x08 MODE (1 = edge, 0 = level); 0x0C THRESHOLD [PRIO_W-1:0]; 0x10 CLAIM (read) / COMPLETE (write); 0x20+4*(ID-1) PRIO[ID]. Unused bits read 0; writes to RO/unmapped offsets ignored.
- Level source: pending = sampled line & ~in_service. Edge source: pending set on sampled 0->1, cleared only by claim.
- Candidate: pending & enable & PRIO > THRESHOLD. Winner = highest PRIO; tie -> lowest ID.
- Claim: read of 0x10 returns winner ID (0 if none); at that clock edge the winner's edge-pending bit clears and its in_service bit sets. Read with no winner has no side effect.
- Complete: write of ID to 0x10 clears in_service[ID]. ID 0, ID > NUM_SRC, or ID not in service: ignored.
- In-service source never becomes a candidate; an edge arriving while in service still latches pending (one deep) and competes after complete.
- Simultaneous claim and new edge on the same source: set wins, pending stays 1, in_service set.
- Simultaneous complete and claim: both take effect; claim uses pre-edge state.
- MODE change of a source clears its edge-pending bit.

## Timing
- Reset: all registers, pending, in_service, sync/history flops 0; irq_o = 0, irq_id_o = 0, data_o = 0.
- src_i rising edge (setup before edge E0): pending set at E0 (E2 with sync), irq_o/irq_id_o valid at E1 (E3 with sync).
- Register writes take effect at the write edge; irq_o reflects them one edge later.
- After claim edge, irq_o/irq_id_o update at the next edge to the next winner or drop to 0.
- data_o is valid in the same cycle as req_i; no wait states, no hold request to ctrl.
- Reset mid-claim: in_service and pending cleared; any lost completes are harmless.

## Configuration
- INT_CTRL_SYNC_EN defined: each src_i passes through a 2-flop synchroniser before level sampling and edge detection (+2 cycles latency).
- Undefined: src_i sampled directly; edge detect compares src_i with a 1-flop history register. For synchronous sources only.

## Structure
- Package int_ctrl_pkg: register offsets, ID_W = 5, MAX_SRC = 31, mode encodings.
- Sub-module int_ctrl_arb: combinational max-priority/lowest-ID tree over candidates, outputs valid + ID + priority.
- Top holds sync, pending, in_service, config registers, bus decode, output register.

## Test plan
- NUM_SRC=8: enable ID3, PRIO[3]=2, THRESHOLD=1, level src_i[2]=1 -> irq_o=1, irq_id_o=3; claim read returns 3; irq_o=0 next edge; complete 3 with line still high -> irq_o=1 again.
- PRIO[2]=5, PRIO[6]=5, PRIO[4]=7, all pending -> claims return 4, 2, 6, then 0.
- THRESHOLD=5, PRIO[1]=5 pending -> irq_o stays 0; THRESHOLD=4 -> irq_o=1 after one edge.
- Edge ID5: pulse, claim, pulse again while in service -> PENDING bit4=1, no irq; complete 5 -> irq_o=1, claim returns 5.
- Complete of ID 0, 9 and non-in-service ID 2 -> no state change; reset asserted during active in_service -> all outputs 0 next edge.
- Latency: src_i rise -> irq_o after 2 edges without INT_CTRL_SYNC_EN, 4 edges with it.
